// File: rtl/am_mod_pipe_pkg.sv
// Shared helpers for the AM modulator datapath: width arithmetic, DC offset and signed saturation.
package am_pkg;

    function automatic int env_width(input int signal_w);
        return signal_w + 2;
    endfunction

    function automatic int prod_width(input int signal_w, input int carrier_w);
        return signal_w + carrier_w + 2;
    endfunction

    function automatic int shift_amount(input int signal_w, input int carrier_w, input int out_w);
        return signal_w + carrier_w - out_w;
    endfunction

    // Unity carrier level in the baseband Q format: 1.0 == 2^(SIGNAL_W-1).
    function automatic int dc_offset(input int signal_w);
        return 1 << (signal_w - 1);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/am_mod_pipe_if.sv
// Valid/ready stream bundle for the AM modulator: baseband/carrier beat in, modulated sample out.
interface am_mod_pipe_if #(
    parameter int CARRIER_W = 8,
    parameter int SIGNAL_W  = 8,
    parameter int MOD_W     = 8,
    parameter int OUT_W     = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [CARRIER_W-1:0] carrier_in;
    logic signed [SIGNAL_W-1:0]  signal_in;
    logic        [MOD_W-1:0]     mod_index;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_W-1:0]     signal_out;

    modport master (
        output in_valid, carrier_in, signal_in, mod_index, out_ready,
        input  in_ready, out_valid, signal_out
    );

    modport slave (
        input  in_valid, carrier_in, signal_in, mod_index, out_ready,
        output in_ready, out_valid, signal_out
    );
endinterface

// File: rtl/am_mod_pipe_sat_trunc.sv
// Arithmetic right shift followed by signed saturation to OUT_W bits; o_sat flags a clipped result.
module am_sat_trunc
    import am_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_sat
);
    logic signed [IN_W-1:0] w_q;
    logic signed [63:0]     w_q64;
    logic signed [63:0]     w_s64;

    assign w_q    = i_din >>> SHIFT;
    assign w_q64  = 64'(w_q);
    assign w_s64  = saturate(w_q64, OUT_W);
    assign o_dout = OUT_W'(w_s64);
    assign o_sat  = (w_s64 != w_q64);
endmodule

// File: rtl/am_mod_pipe.sv
// Three-stage standard-AM modulator: out = sat((1 + m*x) * c / 2) on a valid/ready stream.
// Optional macro AM_ENV_CLAMP_EN clips a negative envelope to zero instead of letting the phase reverse.
module am_mod_pipe
    import am_pkg::*;
#(
    parameter int CARRIER_W = 8,
    parameter int SIGNAL_W  = 8,
    parameter int MOD_W     = 8,
    parameter int OUT_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    am_mod_pipe_if.slave  bus,
    input  logic          clr_status,
    output logic          overmod_flag,
    output logic          sat_flag
);
    localparam int ENV_W  = env_width(SIGNAL_W);
    localparam int PROD_W = prod_width(SIGNAL_W, CARRIER_W);
    localparam int SHIFT  = shift_amount(SIGNAL_W, CARRIER_W, OUT_W);
    localparam int XM_W   = SIGNAL_W + 1;
    localparam int MUL_W  = SIGNAL_W + MOD_W + 1;
    localparam logic signed [ENV_W-1:0] DC = ENV_W'(dc_offset(SIGNAL_W));

    logic                        w_en;
    logic signed [MUL_W-1:0]     w_sig_ext;
    logic signed [MUL_W-1:0]     w_mod_ext;
    logic signed [MUL_W-1:0]     w_mul;
    logic signed [XM_W-1:0]      w_xm;
    logic signed [ENV_W-1:0]     w_env_raw;
    logic signed [ENV_W-1:0]     w_env;
    logic                        w_neg;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [OUT_W-1:0]     w_sat_out;
    logic                        w_sat;

    logic                        r_s1_valid;
    logic signed [CARRIER_W-1:0] r_s1_car;
    logic signed [XM_W-1:0]      r_s1_xm;
    logic                        r_s2_valid;
    logic signed [CARRIER_W-1:0] r_s2_car;
    logic signed [ENV_W-1:0]     r_s2_env;
    logic                        r_s2_neg;
    logic                        r_s3_valid;
    logic signed [OUT_W-1:0]     r_s3_out;

    // Whole pipe moves in lockstep; only a valid beat parked in stage 3 can stall it.
    assign w_en         = !r_s3_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // Stage 1: m is unsigned, so zero-extend it before the signed multiply.
    assign w_sig_ext = MUL_W'(bus.signal_in);
    assign w_mod_ext = MUL_W'({1'b0, bus.mod_index});
    assign w_mul     = w_sig_ext * w_mod_ext;
    assign w_xm      = XM_W'(w_mul >>> (MOD_W - 1));

    // Stage 2: envelope = 1.0 + m*x
    assign w_env_raw = ENV_W'(r_s1_xm) + DC;
    assign w_neg     = w_env_raw[ENV_W-1];
`ifdef AM_ENV_CLAMP_EN
    assign w_env     = w_neg ? '0 : w_env_raw;
`else
    assign w_env     = w_env_raw;
`endif

    // Stage 3: envelope times carrier, rescaled and clipped to the output format
    assign w_prod = PROD_W'(r_s2_env) * PROD_W'(r_s2_car);

    am_sat_trunc #(
        .IN_W  (PROD_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_trunc (
        .i_din  (w_prod),
        .o_dout (w_sat_out),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_car   <= '0;
            r_s1_xm    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_car   <= '0;
            r_s2_env   <= '0;
            r_s2_neg   <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_out   <= '0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_car   <= bus.carrier_in;
            r_s1_xm    <= w_xm;
            r_s2_valid <= r_s1_valid;
            r_s2_car   <= r_s1_car;
            r_s2_env   <= w_env;
            r_s2_neg   <= w_neg;
            r_s3_valid <= r_s2_valid;
            r_s3_out   <= w_sat_out;
        end
    end

    // Events are taken as a beat enters stage 3; a set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overmod_flag <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            if (w_en && r_s2_valid && r_s2_neg) overmod_flag <= 1'b1;
            else if (clr_status)                overmod_flag <= 1'b0;
            if (w_en && r_s2_valid && w_sat)    sat_flag     <= 1'b1;
            else if (clr_status)                sat_flag     <= 1'b0;
        end
    end

    assign bus.out_valid  = r_s3_valid;
    assign bus.signal_out = r_s3_out;
endmodule

// File: tb/tb_am_mod_pipe.sv
// Directed self-checking bench for am_mod_pipe at default widths (m in Q1.7, 128 = 1.0).
module tb_am_mod_pipe;
    logic clk;
    logic rst_n;
    logic clr_status;
    logic overmod_flag;
    logic sat_flag;
    int   errors;
    int   checks;

    am_mod_pipe_if #(.CARRIER_W(8), .SIGNAL_W(8), .MOD_W(8), .OUT_W(8)) bus ();

    am_mod_pipe #(.CARRIER_W(8), .SIGNAL_W(8), .MOD_W(8), .OUT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_status   (clr_status),
        .overmod_flag (overmod_flag),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int m, input int c);
        bus.signal_in  = 8'(x);
        bus.mod_index  = 8'(m);
        bus.carrier_in = 8'(c);
    endtask

    // One beat presented for exactly one accepting edge.
    task automatic send(input int x, input int m, input int c);
        drive(x, m, c);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic int ref_out(input int x, input int m, input int c);
        int xm;
        int env;
        int q;
        xm  = (x * m) >>> 7;
        env = 128 + xm;
`ifdef AM_ENV_CLAMP_EN
        if (env < 0) env = 0;
`endif
        q = (env * c) >>> 8;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    int sx[10];
    int sm[10];
    int sc[10];
    int sent;
    int recv;
    int n;
    int held;
    int exp_c;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        clr_status = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_signal_out", bus.signal_out, 0);
        chk("reset_overmod", overmod_flag, 0);
        chk("reset_sat", sat_flag, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Nominal full-scale beat: env=255, out=126
        send(127, 128, 127);
        chk("A_lat1", bus.out_valid, 0);
        tick();
        chk("A_lat2", bus.out_valid, 0);
        tick();
        chk("A_valid", bus.out_valid, 1);
        chk("A_out", bus.signal_out, 126);
        chk("A_overmod", overmod_flag, 0);
        chk("A_sat", sat_flag, 0);
        tick();
        chk("A_drain", bus.out_valid, 0);

        // env=381, q=-191 -> clipped to -128
        send(127, 255, -128);
        tick();
        tick();
        chk("B_valid", bus.out_valid, 1);
        chk("B_out", bus.signal_out, -128);
        chk("B_sat", sat_flag, 1);
        chk("B_overmod", overmod_flag, 0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("B_clr_sat", sat_flag, 0);

        // env=-127: phase reversal gives -64, clamped envelope gives 0
`ifdef AM_ENV_CLAMP_EN
        exp_c = 0;
`else
        exp_c = -64;
`endif
        send(-128, 255, 127);
        tick();
        tick();
        chk("C_valid", bus.out_valid, 1);
        chk("C_out", bus.signal_out, exp_c);
        chk("C_overmod", overmod_flag, 1);
        chk("C_sat", sat_flag, 0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("C_clr_overmod", overmod_flag, 0);

        // Clear coinciding with a saturating beat entering stage 3
        send(127, 255, -128);
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("D_valid", bus.out_valid, 1);
        chk("D_set_wins", sat_flag, 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("D_clr_later", sat_flag, 0);

        // Back-to-back stream, downstream stalls in cycles 4-6
        for (int i = 0; i < 10; i++) begin
            sx[i] = 20 * i - 90;
            sm[i] = 40 + 20 * i;
            sc[i] = 120 - 25 * i;
        end
        sent = 0;
        recv = 0;
        n = 0;
        held = 0;
        while (recv < 10 && n < 40) begin
            bus.out_ready = !(n >= 4 && n <= 6);
            bus.in_valid = (sent < 10);
            if (sent < 10) drive(sx[sent], sm[sent], sc[sent]);
            #1;
            if (n >= 4 && n <= 6) begin
                chk($sformatf("E_in_ready_c%0d", n), bus.in_ready, 0);
                chk($sformatf("E_hold_valid_c%0d", n), bus.out_valid, 1);
                if (n == 4) held = int'(bus.signal_out);
                else chk($sformatf("E_hold_data_c%0d", n), bus.signal_out, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("E_out%0d", recv), bus.signal_out,
                    ref_out(sx[recv], sm[recv], sc[recv]));
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("E_recv_count", recv, 10);
        chk("E_sent_count", sent, 10);
        tick();
        chk("E_no_extra", bus.out_valid, 0);

        // Asynchronous reset with the pipe full
        drive(127, 128, 127);
        bus.in_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("F_pre_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_rst_valid", bus.out_valid, 0);
        chk("F_rst_out", bus.signal_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("F_no_ghost", bus.out_valid, 0);
        // xm=50, env=178, P=-17800 -> -70
        send(100, 64, -100);
        chk("F_lat1", bus.out_valid, 0);
        tick();
        chk("F_lat2", bus.out_valid, 0);
        tick();
        chk("F_valid", bus.out_valid, 1);
        chk("F_out", bus.signal_out, -70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
